// File: rtl/line_store_merger_pkg.sv
// Shared constants and types for the cache store-merge path.
package line_store_merger_pkg;

    localparam int LINE_NB_BYTES = 16;
    localparam int WORD_WIDTH    = 32;
    localparam int INDEX_WIDTH   = 4;
    localparam int LINE_WIDTH    = LINE_NB_BYTES * 8;

    // Read-modify-write sequencing of one line
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WRITE   = 2'd3
    } merger_state_e;

    // Store size as carried from the MEM stage
    typedef enum logic {
        SIZE_WORD = 1'b0,
        SIZE_BYTE = 1'b1
    } store_size_e;

    // A word store must sit on a 4-byte boundary; byte stores never misalign
    function automatic logic is_misaligned(input store_size_e size, input logic [1:0] offset_lo);
        return (size == SIZE_WORD) && (offset_lo != 2'b00);
    endfunction

endpackage

// File: rtl/line_store_merger_merge.sv
// Combinational little-endian merge of a word or a byte into a cache line.
// Word lane 0 is line[31:0], matching the read-side word select.
module line_word_merge #(
    parameter int LINE_NB_BYTES = line_store_merger_pkg::LINE_NB_BYTES,
    parameter int WORD_WIDTH    = line_store_merger_pkg::WORD_WIDTH
) (
    input  logic [LINE_NB_BYTES*8-1:0]         line_in,
    input  logic [$clog2(LINE_NB_BYTES)-1:0]   offset,
    input  logic [WORD_WIDTH-1:0]              data,
    input  logic                               byte_store,
    output logic [LINE_NB_BYTES*8-1:0]         line_out
);

    localparam int OFFSET_WIDTH  = $clog2(LINE_NB_BYTES);
    localparam int WORD_NB_BYTES = WORD_WIDTH / 8;
    localparam int WORD_SHIFT    = $clog2(WORD_NB_BYTES);

    // Each line byte decides independently whether it is overwritten;
    // the word lane ignores the low offset bits, so no carry into other lanes.
    generate
        for (genvar gi = 0; gi < LINE_NB_BYTES; gi++) begin : gen_byte
            localparam logic [OFFSET_WIDTH-1:0] BYTE_IDX = OFFSET_WIDTH'(gi);
            logic       hit;
            logic [7:0] new_byte;

            assign hit      = byte_store ? (offset == BYTE_IDX)
                                         : ((offset >> WORD_SHIFT) == (BYTE_IDX >> WORD_SHIFT));
            assign new_byte = byte_store ? data[7:0] : data[8*(gi % WORD_NB_BYTES) +: 8];
            assign line_out[8*gi +: 8] = hit ? new_byte : line_in[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/line_store_merger.sv
// Store path read-modify-write on one data-cache line: read, merge, write back.
module line_store_merger #(
    parameter int LINE_NB_BYTES = line_store_merger_pkg::LINE_NB_BYTES,
    parameter int WORD_WIDTH    = line_store_merger_pkg::WORD_WIDTH,
    parameter int INDEX_WIDTH   = line_store_merger_pkg::INDEX_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [INDEX_WIDTH-1:0]             req_index,
    input  logic [$clog2(LINE_NB_BYTES)-1:0]   req_offset,
    input  logic [WORD_WIDTH-1:0]              req_data,
    input  logic                               req_byte,
    output logic                               rd_en,
    output logic [INDEX_WIDTH-1:0]             rd_index,
    input  logic [LINE_NB_BYTES*8-1:0]         rd_line,
    output logic                               wr_en,
    output logic [INDEX_WIDTH-1:0]             wr_index,
    output logic [LINE_NB_BYTES*8-1:0]         wr_line,
    output logic                               done,
    output logic                               err_misaligned
);

    import line_store_merger_pkg::*;

    localparam int LW = LINE_NB_BYTES * 8;
    localparam int OW = $clog2(LINE_NB_BYTES);

    merger_state_e          state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [OW-1:0]          off_q, off_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    store_size_e            size_q, size_d;
    store_size_e            req_size;
    logic                   req_ready_q, req_ready_d;
    logic                   rd_en_q, rd_en_d;
    logic [INDEX_WIDTH-1:0] rd_index_q, rd_index_d;
    logic                   wr_en_q, wr_en_d;
    logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
    logic [LW-1:0]          wr_line_q, wr_line_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [LW-1:0]          merged_line;

    assign req_size = req_byte ? SIZE_BYTE : SIZE_WORD;

    // rd_line is merged as it arrives, so capturing the line and forming
    // the write data happen on the same edge
    line_word_merge #(
        .LINE_NB_BYTES (LINE_NB_BYTES),
        .WORD_WIDTH    (WORD_WIDTH)
    ) u_merge (
        .line_in    (rd_line),
        .offset     (off_q),
        .data       (data_q),
        .byte_store (size_q == SIZE_BYTE),
        .line_out   (merged_line)
    );

    // Next-state and next-output computation for the RMW sequence
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        off_d       = off_q;
        data_d      = data_q;
        size_d      = size_q;
        req_ready_d = req_ready_q;
        rd_en_d     = 1'b0;
        rd_index_d  = rd_index_q;
        wr_en_d     = 1'b0;
        wr_index_d  = wr_index_q;
        wr_line_d   = wr_line_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d  = req_index;
                    off_d  = req_offset;
                    data_d = req_data;
                    size_d = req_size;
                    if (is_misaligned(req_size, req_offset[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = ST_READ;
                        rd_en_d     = 1'b1;
                        rd_index_d  = req_index;
                        req_ready_d = 1'b0;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d    = ST_WRITE;
                wr_en_d    = 1'b1;
                done_d     = 1'b1;
                wr_index_d = idx_q;
                wr_line_d  = merged_line;
            end
            ST_WRITE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset aborts any store in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            off_q       <= '0;
            data_q      <= '0;
            size_q      <= SIZE_WORD;
            req_ready_q <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_index_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_index_q  <= '0;
            wr_line_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            data_q      <= data_d;
            size_q      <= size_d;
            req_ready_q <= req_ready_d;
            rd_en_q     <= rd_en_d;
            rd_index_q  <= rd_index_d;
            wr_en_q     <= wr_en_d;
            wr_index_q  <= wr_index_d;
            wr_line_q   <= wr_line_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rd_en          = rd_en_q;
    assign rd_index       = rd_index_q;
    assign wr_en          = wr_en_q;
    assign wr_index       = wr_index_q;
    assign wr_line        = wr_line_q;
    assign done           = done_q;
    assign err_misaligned = err_q;

endmodule

// File: tb/tb_line_store_merger.sv
// Scoreboard bench: byte-level reference memory predicts every write-back
// and misalignment pulse; a negedge monitor checks what the DUT presents.
module tb_line_store_merger;

    import line_store_merger_pkg::*;

    localparam int NB     = LINE_NB_BYTES;
    localparam int LW     = LINE_WIDTH;
    localparam int IW     = INDEX_WIDTH;
    localparam int OW     = $clog2(NB);
    localparam int NLINES = 1 << IW;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_index;
    logic [OW-1:0] req_offset;
    logic [31:0]   req_data;
    logic          req_byte;
    logic          rd_en;
    logic [IW-1:0] rd_index;
    logic [LW-1:0] rd_line;
    logic          wr_en;
    logic [IW-1:0] wr_index;
    logic [LW-1:0] wr_line;
    logic          done;
    logic          err_misaligned;

    line_store_merger dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_index      (req_index),
        .req_offset     (req_offset),
        .req_data       (req_data),
        .req_byte       (req_byte),
        .rd_en          (rd_en),
        .rd_index       (rd_index),
        .rd_line        (rd_line),
        .wr_en          (wr_en),
        .wr_index       (wr_index),
        .wr_line        (wr_line),
        .done           (done),
        .err_misaligned (err_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_cnt = 0;
    int last_wr = -100;
    int prev_wr = -100;

    always @(posedge clk) cyc <= cyc + 1;

    // Data-array model: write-first, registered read, plus a bench preload port
    logic [LW-1:0] arr [NLINES];
    logic          pl_en = 1'b0;
    logic [IW-1:0] pl_idx = '0;
    logic [LW-1:0] pl_line = '0;

    always @(posedge clk) begin
        if (pl_en) arr[pl_idx] = pl_line;
        if (wr_en) arr[wr_index] = wr_line;
        if (rd_en) rd_line <= arr[rd_index];
    end

    // Reference memory kept as individual bytes
    logic [7:0] ref_bytes [NLINES][NB];

    typedef struct {
        bit            is_err;
        logic [IW-1:0] idx;
        logic [LW-1:0] line;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [LW-1:0] ref_line(input int idx);
        logic [LW-1:0] l;
        for (int b = 0; b < NB; b++) l[8*b +: 8] = ref_bytes[idx][b];
        return l;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_line(input int idx, input logic [LW-1:0] v);
        @(negedge clk);
        pl_en = 1'b1;
        pl_idx = IW'(idx);
        pl_line = v;
        for (int b = 0; b < NB; b++) ref_bytes[idx][b] = v[8*b +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Present a store, wait for the handshake, then record the prediction.
    // Returns 1 time unit after the accepting edge.
    task automatic do_store(input logic [IW-1:0] idx, input logic [OW-1:0] off,
                            input logic [31:0] data, input bit byt,
                            input bit hold, input bit abort, output int acc_cyc);
        bit rdy;
        bit accepted;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_index  = idx;
        req_offset = off;
        req_data   = data;
        req_byte   = byt;
        accepted   = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) accepted = 1'b1;
            else @(negedge clk);
        end
        #1;
        acc_cyc = cyc;
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no handshake expected req_ready within 20 cycles");
        end else if (!abort) begin
            e.idx = idx;
            if (!byt && off[1:0] != 2'b00) begin
                e.is_err = 1'b1;
                e.line   = '0;
            end else begin
                e.is_err = 1'b0;
                if (byt) ref_bytes[idx][off] = data[7:0];
                else for (int b = 0; b < 4; b++) ref_bytes[idx][int'(off) + b] = data[8*b +: 8];
                e.line = ref_line(idx);
            end
            sb_q.push_back(e);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    // Monitor: every write-back or misalignment pulse consumes one prediction
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (wr_en || done) check("done_with_wr_en", LW'(done), LW'(wr_en));
            if (wr_en) begin
                prev_wr = last_wr;
                last_wr = cyc;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got wr_en idx %0d expected no write", wr_index);
                end else begin
                    e = sb_q.pop_front();
                    check("wb_kind", LW'(0), LW'(e.is_err));
                    check("wb_index", LW'(wr_index), LW'(e.idx));
                    check("wb_line", wr_line, e.line);
                end
            end
            if (err_misaligned) begin
                err_cnt++;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_err: got err_misaligned expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("err_kind", LW'(1), LW'(e.is_err));
                end
            end
        end
    end

    initial begin
        int a1, a2, e0, dummy;
        logic [LW-1:0] ones;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_index  = '0;
        req_offset = '0;
        req_data   = '0;
        req_byte   = 1'b0;
        ones       = '1;
        rd_line    = '0;
        for (int i = 0; i < NLINES; i++)
            set_line(i, {$urandom, $urandom, $urandom, $urandom});

        // Reset state
        #1;
        check("rst_req_ready", LW'(req_ready), LW'(1));
        check("rst_rd_en", LW'(rd_en), LW'(0));
        check("rst_wr_en", LW'(wr_en), LW'(0));
        check("rst_done_err", LW'({done, err_misaligned}), LW'(0));
        check("rst_indices", LW'({rd_index, wr_index}), LW'(0));
        check("rst_wr_line", wr_line, LW'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Word store, offset 4, over a zero line: latency and lane placement
        set_line(3, '0);
        do_store(4'd3, 4'd4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, dummy);
        check("t1_rd_en_c1", LW'(rd_en), LW'(1));
        check("t1_rd_index_c1", LW'(rd_index), LW'(3));
        @(posedge clk); #1;
        check("t1_c2_quiet", LW'({rd_en, wr_en}), LW'(0));
        @(posedge clk); #1;
        check("t1_wr_done_c3", LW'({wr_en, done}), LW'(2'b11));
        check("t1_wr_index", LW'(wr_index), LW'(3));
        check("t1_wr_line", wr_line, {64'h0, 32'hDEADBEEF, 32'h0});

        // Byte store at the last offset over an all-ones line
        set_line(5, ones);
        do_store(4'd5, 4'd15, 32'h000000A5, 1'b1, 1'b0, 1'b0, dummy);
        @(posedge clk); @(posedge clk); #1;
        check("t2_wr_en", LW'(wr_en), LW'(1));
        check("t2_wr_line", wr_line, {8'hA5, {120{1'b1}}});

        // Word store into the top lane
        set_line(9, 128'h0123456789ABCDEF_FEDCBA9876543210);
        do_store(4'd9, 4'd12, 32'h11223344, 1'b0, 1'b0, 1'b0, dummy);
        @(posedge clk); @(posedge clk); #1;
        check("t6_wr_line", wr_line, 128'h11223344_89ABCDEF_FEDCBA98_76543210);

        // Misaligned word store
        @(posedge clk);
        e0 = err_cnt;
        do_store(4'd2, 4'd6, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, dummy);
        check("t3_err_c1", LW'(err_misaligned), LW'(1));
        check("t3_ready_c1", LW'(req_ready), LW'(1));
        check("t3_rd_en_c1", LW'(rd_en), LW'(0));
        @(posedge clk); #1;
        check("t3_quiet_c2", LW'({err_misaligned, rd_en, wr_en}), LW'(0));
        check("t3_ready_c2", LW'(req_ready), LW'(1));
        @(posedge clk); #1;
        check("t3_err_once", LW'(err_cnt - e0), LW'(1));

        // Back-to-back on the same line with req_valid held
        do_store(4'd7, 4'd0, $urandom, 1'b0, 1'b1, 1'b0, a1);
        do_store(4'd7, 4'd2, $urandom, 1'b1, 1'b0, 1'b0, a2);
        check("t4_accept_gap", LW'(a2 - a1), LW'(4));
        repeat (4) @(posedge clk);
        #1;
        check("t4_wr_gap", LW'(last_wr - prev_wr), LW'(4));

        // Reset asserted during CAPTURE aborts the store
        do_store(4'd11, 4'd8, 32'h55AA55AA, 1'b0, 1'b0, 1'b1, dummy);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_ready_in_rst", LW'(req_ready), LW'(1));
        check("t5_rd_wr_in_rst", LW'({rd_en, wr_en, done}), LW'(0));
        check("t5_wr_line_in_rst", wr_line, LW'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t5_line_untouched", arr[11], ref_line(11));

        // Randomized stores, mixing sizes, alignments and held requests
        for (int t = 0; t < 40; t++) begin
            logic [IW-1:0] ridx;
            logic [OW-1:0] roff;
            bit rbyte;
            bit rhold;
            ridx  = IW'($urandom);
            roff  = OW'($urandom);
            rbyte = 1'($urandom);
            rhold = 1'($urandom);
            if (!rbyte && ($urandom_range(0, 3) != 0)) roff[1:0] = 2'b00;
            do_store(ridx, roff, $urandom, rbyte, rhold, 1'b0, dummy);
            if (!rhold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;

        // Drain with a bounded wait
        for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", LW'(sb_q.size()), LW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_store_merger.md
Name: line_store_merger

Overview:
- Write-direction counterpart of the cache word-select path: merges a 32-bit word or a single byte into a cache line at a byte offset.
- Sits between the MEM stage store path and the data-cache data array.
- Performs a read-modify-write on one line: reads the line through the array read port, merges the store data, writes the line back.
- Accepts one store per transaction with a valid/ready handshake.

Parameters:
- LINE_NB_BYTES, 16, bytes per cache line (power of two, >= 4)
- WORD_WIDTH, 32, store word width; equals INSTRUCTION_LENGTH
- INDEX_WIDTH, 4, cache line index width
- LINE_WIDTH, LINE_NB_BYTES*8, line width in bits (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  merger can accept a request
- req_index  in  INDEX_WIDTH  target line index
- req_offset  in  $clog2(LINE_NB_BYTES)  byte offset within line
- req_data  in  WORD_WIDTH  store data; byte stores use [7:0]
- req_byte  in  1  1 = byte store (STB), 0 = word store
- rd_en  out  1  array read strobe
- rd_index  out  INDEX_WIDTH  array read index
- rd_line  in  LINE_WIDTH  array read data, valid the cycle after rd_en
- wr_en  out  1  array write strobe
- wr_index  out  INDEX_WIDTH  array write index
- wr_line  out  LINE_WIDTH  merged line to write
- done  out  1  one-cycle pulse when the write is issued
- err_misaligned  out  1  one-cycle pulse when a word store is rejected

Behaviour:
- Reset (reset_n low, asynchronous) forces state IDLE and clears all registers.
  - req_ready=1; rd_en, wr_en, done and err_misaligned = 0; rd_index, wr_index and wr_line = 0.
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid: register index, offset, data and byte.
  - Misaligned word store (req_byte=0 and offset[1:0]!=0): pulse err_misaligned next cycle, stay in IDLE, no array access.
  - Otherwise go to READ.
- READ: rd_en=1, rd_index=the registered index, for exactly one cycle; then go to CAPTURE.
- CAPTURE: register rd_line, then go to WRITE.
- WRITE:
  - wr_en=1, wr_index=the registered index, wr_line=the merged line, done=1, for one cycle.
  - Next state is IDLE.
- Latency: accept at edge 0; rd_en during cycle 1; line captured at the end of cycle 2; wr_en and done during cycle 3.
  - Throughput is one store per 4 cycles.
- req_ready is 0 in READ, CAPTURE and WRITE. req_valid is ignored while busy; the requester holds the request.
- Merge is little-endian:
  - Word store: lane k=offset[$clog2(LINE_NB_BYTES)-1:2]; bits [32k+31:32k] are replaced by req_data.
  - Byte store: bits [8*offset+7:8*offset] are replaced by req_data[7:0].
  - All other bits pass through unchanged from rd_line.
- Word lane 0 is line[31:0], consistent with the read-side word selection.
- Boundaries:
  - Offset LINE_NB_BYTES-1 byte store and the top word lane must merge correctly with no wrap into bit 0.
  - Reset asserted mid-transaction aborts it; wr_en is never asserted for the aborted store.
  - Back-to-back: a request held valid during WRITE is accepted at the first IDLE cycle.
- All outputs are registered; none depend combinationally on req_* inputs.

Decomposition:
- Shared package holds:
  - LINE_NB_BYTES, LINE_WIDTH and WORD_WIDTH constants.
  - The merger state enum (IDLE/READ/CAPTURE/WRITE).
  - The store-size encoding (byte/word).
- One combinational sub-module, line_word_merge, takes (line, offset, data, byte) and produces the merged line.
  - It is reused by any future write-through path and unit-tested standalone.

Test Plan:
- Word store idx 3, offset 4, data 0xDEADBEEF, rd_line all-zero:
  - rd_en in cycle 1 with rd_index 3.
  - wr_en and done in cycle 3, wr_line[63:32]=0xDEADBEEF, all other bits 0.
- Byte store offset 15, data 0x000000A5, rd_line all-ones:
  - wr_line[127:120]=0xA5, remaining bits all ones.
- Word store offset 6:
  - err_misaligned pulses once.
  - rd_en and wr_en stay 0; req_ready stays 1.
- Two stores with req_valid held continuously:
  - Second accepted the cycle after done.
  - Two wr_en pulses 4 cycles apart.
  - Second read sees the first's write when the array model is write-first.
- reset_n driven low during CAPTURE:
  - Immediate return to IDLE, no wr_en pulse, req_ready=1 while reset.
- Word store offset 12 over rd_line 0x0123456789ABCDEF_FEDCBA9876543210 with data 0x11223344:
  - wr_line[127:96]=0x11223344, lower 96 bits unchanged.
